inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 27 ++
 rtl/inst_loader_word_packer.sv | 58 +++++
 rtl/inst_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction loader: FSM states, error codes and
// the image word geometry.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CSUM  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE    = 2'b00;
    localparam err_t ERR_CSUM    = 2'b01;
    localparam err_t ERR_TIMEOUT = 2'b10;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic state_accepts(input state_t s);
        return (s == S_COUNT) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/inst_loader_word_packer.sv
// Assembles little-endian image bytes into 32-bit instruction words and
// issues a one-cycle write strobe one cycle after the fourth byte of a word.
module word_packer
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] word_idx,
    output logic              word_end
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    assign word_end = byte_en && (byte_idx == 2'd3);

    // Byte placement, word index tracking and the registered write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
            word_idx  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
            word_idx  <= '0;
            wr_en     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (byte_en) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: low_bytes[7:0]   <= byte_data;
                    2'd1: low_bytes[15:8]  <= byte_data;
                    2'd2: low_bytes[23:16] <= byte_data;
                    default: begin
                        wr_en    <= 1'b1;
                        wr_addr  <= word_idx;
                        wr_data  <= {byte_data, low_bytes};
                        word_idx <= word_idx + 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a counted, checksummed byte image,
// writes it into instruction memory and releases the core from reset only
// once the whole image has been verified.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam int             TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    err_t              err_q;
    err_t              err_d;
    logic              done_q;
    logic              cpu_rst_q;
    logic [7:0]        count_q;
    logic [7:0]        sum_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              xfer;
    logic              count_xfer;
    logic              data_xfer;
    logic              csum_xfer;
    logic              word_end;
    logic              last_word;
    logic              tmo_hit;
    logic              waiting;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W+7:0] idx_ext;
    logic [ADDR_W+7:0] count_ext;

    assign byte_ready = state_accepts(state_q);
    assign xfer       = byte_valid && byte_ready && !load_start;
    assign count_xfer = xfer && (state_q == S_COUNT);
    assign data_xfer  = xfer && (state_q == S_DATA);
    assign csum_xfer  = xfer && (state_q == S_CSUM);
    assign waiting    = (state_q == S_DATA) || (state_q == S_CSUM);

    assign idx_ext    = {8'd0, word_idx};
    assign count_ext  = {{ADDR_W{1'b0}}, count_q};
    assign last_word  = word_end && (idx_ext == count_ext);
    assign tmo_hit    = waiting && !xfer && !load_start && (tmo_q == TMO_LAST);

    word_packer #(
        .ADDR_W(ADDR_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (load_start || count_xfer),
        .byte_en  (data_xfer),
        .byte_data(byte_data),
        .wr_en    (imem_wr_en),
        .wr_addr  (imem_wr_addr),
        .wr_data  (imem_wr_data),
        .word_idx (word_idx),
        .word_end (word_end)
    );

    // State, error code and the registered core-release outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_COUNT;
            err_q     <= ERR_NONE;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            done_q    <= (state_d == S_DONE);
            cpu_rst_q <= (state_d == S_DONE);
        end
    end

    // Next-state decode; load_start overrides everything and restarts reception.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (load_start) begin
            state_d = S_COUNT;
            err_d   = ERR_NONE;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (count_xfer) state_d = S_DATA;
                end
                S_DATA: begin
                    if (tmo_hit) begin
                        state_d = S_ERR;
                        err_d   = ERR_TIMEOUT;
                    end else if (last_word) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (tmo_hit) begin
                        state_d = S_ERR;
                        err_d   = ERR_TIMEOUT;
                    end else if (csum_xfer) begin
                        if (byte_data == sum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                            err_d   = ERR_CSUM;
                        end
                    end
                end
                S_DONE: state_d = S_DONE;
                S_ERR:  state_d = S_ERR;
                default: state_d = S_COUNT;
            endcase
        end
    end

    // Word count latch, running mod-256 checksum and inter-byte idle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
            sum_q   <= 8'd0;
            tmo_q   <= '0;
        end else if (load_start) begin
            count_q <= 8'd0;
            sum_q   <= 8'd0;
            tmo_q   <= '0;
        end else begin
            if (count_xfer) begin
                count_q <= byte_data;
                sum_q   <= 8'd0;
            end else if (data_xfer) begin
                sum_q <= sum_q + byte_data;
            end
            if (xfer) begin
                tmo_q <= '0;
            end else if (waiting) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign done      = done_q;
    assign cpu_rst_n = cpu_rst_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader, built with a short timeout so
// the idle-timer path can be exercised in a handful of cycles.
module tb_inst_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;
    logic              cpu_rst_n;
    logic              done;
    logic [1:0]        err_code;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_words[256];

    inst_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .cpu_rst_n   (cpu_rst_n),
        .done        (done),
        .err_code    (err_code)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Record every instruction-memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            log_addr.push_back(imem_wr_addr);
            log_data.push_back(imem_wr_data);
        end
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte for exactly one rising edge; called and returns at a negedge.
    task automatic applyStimulus(input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseLoadStart();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic sendImage033(input logic [7:0] csum);
        applyStimulus(8'h01);
        applyStimulus(8'h13); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00);
        applyStimulus(csum);
        idle(1);
    endtask

    initial begin
        logic [7:0] bsum;
        logic [7:0] d;
        int bad;
        int n;

        rst_n      = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(2);
        checkOutput("rst_wr_en",   32'(imem_wr_en),   32'd0);
        checkOutput("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
        checkOutput("rst_wr_data", imem_wr_data,      32'd0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst_n),    32'd0);
        checkOutput("rst_done",    32'(done),         32'd0);
        checkOutput("rst_err",     32'(err_code),     32'd0);
        rst_n = 1'b1;
        idle(1);
        checkOutput("rst_ready", 32'(byte_ready), 32'd1);

        $display("[TB] good two-word image");
        clearLog();
        sendImage033(8'hB6);
        checkOutput("good_nwr",   32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            checkOutput("good_a0", 32'(log_addr[0]), 32'd0);
            checkOutput("good_d0", log_data[0],      32'h00000013);
            checkOutput("good_a1", 32'(log_addr[1]), 32'd1);
            checkOutput("good_d1", log_data[1],      32'h00100093);
        end
        checkOutput("good_done",  32'(done),       32'd1);
        checkOutput("good_cpu",   32'(cpu_rst_n),  32'd1);
        checkOutput("good_err",   32'(err_code),   32'd0);
        checkOutput("good_ready", 32'(byte_ready), 32'd0);

        $display("[TB] bad checksum");
        pulseLoadStart();
        checkOutput("ls_done",  32'(done),       32'd0);
        checkOutput("ls_cpu",   32'(cpu_rst_n),  32'd0);
        checkOutput("ls_ready", 32'(byte_ready), 32'd1);
        clearLog();
        sendImage033(8'hB7);
        checkOutput("bad_nwr",   32'(log_addr.size()), 32'd2);
        checkOutput("bad_err",   32'(err_code),   32'd1);
        checkOutput("bad_done",  32'(done),       32'd0);
        checkOutput("bad_cpu",   32'(cpu_rst_n),  32'd0);
        checkOutput("bad_ready", 32'(byte_ready), 32'd0);

        $display("[TB] timeout");
        pulseLoadStart();
        clearLog();
        applyStimulus(8'h00);
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        idle(TIMEOUT - 1);
        checkOutput("tmo_early_err", 32'(err_code), 32'd0);
        idle(1);
        checkOutput("tmo_err",   32'(err_code),        32'd2);
        checkOutput("tmo_nwr",   32'(log_addr.size()), 32'd0);
        checkOutput("tmo_ready", 32'(byte_ready),      32'd0);
        checkOutput("tmo_cpu",   32'(cpu_rst_n),       32'd0);

        $display("[TB] load_start during data");
        pulseLoadStart();
        checkOutput("ls_err_clr", 32'(err_code), 32'd0);
        clearLog();
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        load_start = 1'b1;
        applyStimulus(8'hCC);
        load_start = 1'b0;
        applyStimulus(8'h00);
        applyStimulus(8'h78); applyStimulus(8'h56); applyStimulus(8'h34); applyStimulus(8'h12);
        applyStimulus(8'h14);
        idle(1);
        checkOutput("abort_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() >= 1) begin
            checkOutput("abort_a0", 32'(log_addr[0]), 32'd0);
            checkOutput("abort_d0", log_data[0],      32'h12345678);
        end
        checkOutput("abort_done", 32'(done), 32'd1);

        $display("[TB] 256-word image with gaps");
        pulseLoadStart();
        clearLog();
        bsum = 8'h00;
        applyStimulus(8'hFF);
        for (int w = 0; w < 256; w++) begin
            for (int b = 0; b < 4; b++) begin
                d = 8'($urandom_range(0, 255));
                exp_words[w][8*b +: 8] = d;
                bsum = bsum + d;
                applyStimulus(d);
                idle($urandom_range(0, 3));
            end
        end
        applyStimulus(bsum);
        idle(1);
        checkOutput("bulk_nwr", 32'(log_addr.size()), 32'd256);
        bad = 0;
        n = (log_addr.size() < 256) ? log_addr.size() : 256;
        for (int i = 0; i < n; i++) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== exp_words[i]) bad++;
        end
        checkOutput("bulk_bad_entries", 32'(bad), 32'd0);
        if (log_addr.size() >= 256) begin
            checkOutput("bulk_last_addr", 32'(log_addr[255]), 32'hFF);
        end
        checkOutput("bulk_done", 32'(done),     32'd1);
        checkOutput("bulk_err",  32'(err_code), 32'd0);

        $display("[TB] reset mid-load");
        pulseLoadStart();
        clearLog();
        applyStimulus(8'h01);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        applyStimulus(8'h44); applyStimulus(8'h55); applyStimulus(8'h66);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_nwr",     32'(log_addr.size()), 32'd1);
        if (log_addr.size() >= 1) begin
            checkOutput("mid_d0", log_data[0], 32'h44332211);
        end
        checkOutput("mid_wr_en",   32'(imem_wr_en),   32'd0);
        checkOutput("mid_wr_addr", 32'(imem_wr_addr), 32'd0);
        checkOutput("mid_wr_data", imem_wr_data,      32'd0);
        checkOutput("mid_cpu",     32'(cpu_rst_n),    32'd0);
        checkOutput("mid_done",    32'(done),         32'd0);
        checkOutput("mid_err",     32'(err_code),     32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        checkOutput("mid_ready", 32'(byte_ready), 32'd1);
        clearLog();
        applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
        applyStimulus(8'h0A);
        idle(1);
        checkOutput("post_nwr", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() >= 1) begin
            checkOutput("post_a0", 32'(log_addr[0]), 32'd0);
            checkOutput("post_d0", log_data[0],      32'h04030201);
        end
        checkOutput("post_done", 32'(done),      32'd1);
        checkOutput("post_cpu",  32'(cpu_rst_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
